// File: rtl/mandelbrot_pkg.sv
// Shared fixed-point types and constants for the Mandelbrot escape-time iterator.
package mandelbrot_pkg;

  localparam int W    = 32;
  localparam int FRAC = 28;

  typedef logic signed [W-1:0] fx_t;

  localparam fx_t FX_ONE = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  // |z|^2 threshold: 4.0 in the 2*FRAC scale of a full product, one guard bit wide.
  localparam logic signed [2*W:0] ESC_LIMIT =
    {{(2*W-2*FRAC-2){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } iter_state_e;

endpackage

// File: rtl/mandel_fx_mul.sv
// Combinational signed WIDTH x WIDTH -> 2*WIDTH full-precision multiplier.
module mandel_fx_mul
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = W
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] a_x;
  logic signed [2*WIDTH-1:0] b_x;

  assign a_x = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_x = {{WIDTH{b[WIDTH-1]}}, b};
  assign p   = a_x * b_x;

endmodule

// File: rtl/mandelbrot_iterator.sv
// Escape-time iterator: runs z <- z^2 + c one step per clock for a single tagged point.
module mandelbrot_iterator
  import mandelbrot_pkg::*;
#(
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [9:0]       in_x,
  input  logic [9:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_escaped,
  output logic [9:0]       out_x,
  output logic [9:0]       out_y,
  output logic             busy
);

  // Arithmetic shift (floor) then keep the low W bits.
  function automatic fx_t shift_trunc(input logic signed [2*W:0] v, input int sh);
    logic signed [2*W:0] t;
    t = v >>> sh;
    return fx_t'(t);
  endfunction

  iter_state_e state_q, state_d;

  fx_t a_q, b_q;
  logic [9:0] x_q, y_q;
  logic load;

  fx_t zr_q, zr_d, zi_q, zi_d;
  logic [CNT_W-1:0] n_q, n_d, n_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic esc_q, esc_d;
  logic [9:0] out_x_q, out_x_d, out_y_q, out_y_d;

  logic signed [2*W-1:0] sq_r, sq_i, x_ri;
  logic signed [2*W:0]   sq_r_x, sq_i_x, x_ri_x, mag;
  logic escape;

  mandel_fx_mul #(.WIDTH(W)) u_mul_rr (.a(zr_q), .b(zr_q), .p(sq_r));
  mandel_fx_mul #(.WIDTH(W)) u_mul_ii (.a(zi_q), .b(zi_q), .p(sq_i));
  mandel_fx_mul #(.WIDTH(W)) u_mul_ri (.a(zr_q), .b(zi_q), .p(x_ri));

  assign sq_r_x = {sq_r[2*W-1], sq_r};
  assign sq_i_x = {sq_i[2*W-1], sq_i};
  assign x_ri_x = {x_ri[2*W-1], x_ri};
  assign mag    = sq_r_x + sq_i_x;
  // Strictly greater: a point sitting exactly on |z| = 2 keeps iterating.
  assign escape = (mag > ESC_LIMIT);

  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    esc_d   = esc_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    load    = 1'b0;
    n_inc   = n_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          zr_d    = '0;
          zi_d    = '0;
          n_d     = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (escape) begin
          cnt_d   = n_q;
          esc_d   = 1'b1;
          out_x_d = x_q;
          out_y_d = y_q;
          state_d = DONE;
        end else if (n_inc == CNT_W'(MAX_ITER)) begin
          cnt_d   = CNT_W'(MAX_ITER);
          esc_d   = 1'b0;
          out_x_d = x_q;
          out_y_d = y_q;
          state_d = DONE;
        end else begin
          // 2*zr*zi comes from one product with one less fractional shift.
          zr_d = shift_trunc(sq_r_x - sq_i_x, FRAC) + a_q;
          zi_d = shift_trunc(x_ri_x, FRAC - 1) + b_q;
          n_d  = n_inc;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      esc_q   <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      esc_q   <= esc_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
    end
  end

  // Captured point operands need no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= in_a;
      b_q <= in_b;
      x_q <= in_x;
      y_q <= in_y;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = !in_ready;
  assign out_valid   = (state_q == DONE);
  assign out_count   = cnt_q;
  assign out_escaped = esc_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed bench for mandelbrot_iterator: hand-computed points, stall, reset and random sweep.
module tb_mandelbrot_iterator;

  localparam int ONE  = 1 << 28;
  localparam int TWO  = 1 << 29;
  localparam int NEG2 = -(1 << 29);

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [9:0]  in_x, in_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_count;
  logic        out_escaped;
  logic [9:0]  out_x, out_y;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  mandelbrot_iterator #(.MAX_ITER(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_escaped(out_escaped),
    .out_x(out_x), .out_y(out_y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int b, input logic [9:0] x, input logic [9:0] y);
    int g;
    g = 0;
    while (!in_ready && g < 1000) begin
      tick;
      g++;
    end
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_x = x;
    in_y = y;
    tick;
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 600) begin
      tick;
      lat++;
    end
    chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic take;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("valid_dropped", out_valid, 0);
  endtask

  // Bit-exact fixed-point reference of the escape-time recurrence.
  function automatic void ref_point(input int a, input int b, output int cnt, output bit esc);
    int zr, zi;
    longint sr, si, xr;
    zr = 0;
    zi = 0;
    cnt = 255;
    esc = 1'b0;
    for (int n = 0; n < 255; n++) begin
      sr = longint'(zr) * longint'(zr);
      si = longint'(zi) * longint'(zi);
      xr = longint'(zr) * longint'(zi);
      if (sr + si > (longint'(4) <<< 56)) begin
        cnt = n;
        esc = 1'b1;
        return;
      end
      if (n + 1 == 255) begin
        cnt = 255;
        esc = 1'b0;
        return;
      end
      zr = int'((sr - si) >>> 28) + a;
      zi = int'(xr >>> 27) + b;
    end
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rc;
    bit re;
    int ra, rb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0; in_b = '0; in_x = '0; in_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_escaped", out_escaped, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick;

    // c = 1.0: z 0,1,2,5 -> escapes at n=3, 4 clocks after accept
    send(ONE, 0, 10'd1, 10'd2);
    wait_out(lat);
    chk("c1_latency", lat, 4);
    chk("c1_count", out_count, 3);
    chk("c1_escaped", out_escaped, 1);
    chk("c1_x", out_x, 1);
    chk("c1_y", out_y, 2);
    take;

    // c = 2.0: |z|^2 == 4 at n=1 must not escape; escapes at n=2
    send(TWO, 0, 10'd3, 10'd4);
    wait_out(lat);
    chk("c2_latency", lat, 3);
    chk("c2_count", out_count, 2);
    chk("c2_escaped", out_escaped, 1);
    take;

    // c = -2.0: z sticks at 2, runs to the cap
    send(NEG2, 0, 10'd5, 10'd6);
    wait_out(lat);
    chk("cm2_latency", lat, 255);
    chk("cm2_count", out_count, 255);
    chk("cm2_escaped", out_escaped, 0);
    take;

    // c = j: period-2 orbit, runs to the cap
    send(0, ONE, 10'd7, 10'd8);
    wait_out(lat);
    chk("cj_latency", lat, 255);
    chk("cj_count", out_count, 255);
    chk("cj_escaped", out_escaped, 0);
    take;

    // Stall with out_ready low while a new point is held on the input
    send(ONE, 0, 10'd639, 10'd479);
    wait_out(lat);
    chk("stall_latency", lat, 4);
    in_valid = 1'b1;
    in_a = TWO; in_b = 0; in_x = 10'd11; in_y = 10'd12;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_count", out_count, 3);
      chk("stall_escaped", out_escaped, 1);
      chk("stall_x", out_x, 639);
      chk("stall_y", out_y, 479);
      chk("stall_in_ready", in_ready, 0);
      tick;
    end
    out_ready = 1'b1;
    chk("handshake_in_ready", in_ready, 0);
    tick;
    out_ready = 1'b0;
    chk("after_hs_valid", out_valid, 0);
    chk("after_hs_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("held_point_busy", busy, 1);
    wait_out(lat);
    chk("held_latency", lat, 3);
    chk("held_count", out_count, 2);
    chk("held_x", out_x, 11);
    chk("held_y", out_y, 12);
    take;

    // Async reset mid-iteration (n = 7)
    send(0, ONE, 10'd20, 10'd21);
    repeat (7) tick;
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_count", out_count, 0);
    chk("midrst_out_x", out_x, 0);
    #2;
    rst = 1'b0;
    tick;
    chk("postrst_no_output", out_valid, 0);
    send(ONE, 0, 10'd30, 10'd31);
    wait_out(lat);
    chk("postrst_latency", lat, 4);
    chk("postrst_count", out_count, 3);
    chk("postrst_escaped", out_escaped, 1);
    chk("postrst_x", out_x, 30);
    take;

    // Back-to-back random in-range points with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra = int'($urandom_range(32'd1073741824, 32'd0)) - TWO;
      rb = int'($urandom_range(32'd1073741824, 32'd0)) - TWO;
      ref_point(ra, rb, rc, re);
      send(ra, rb, 10'(100 + i), 10'(200 + i));
      wait_out(lat);
      chk("rnd_latency", lat, (rc == 255) ? 255 : rc + 1);
      chk("rnd_count", out_count, rc);
      chk("rnd_escaped", out_escaped, re);
      chk("rnd_x_order", out_x, 100 + i);
      chk("rnd_y_order", out_y, 200 + i);
      tick;
      chk("rnd_consumed", out_valid, 0);
    end
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
